lc3b_mem_responder: RTL and testbench
=====================================

# lc3b_mem_responder

Memory-side responder for the LC-3b processor's single-port memory interface. It answers the datapath/control initiator's `mem_read`/`mem_write` requests after a fixed, parameterised latency, applies the byte write mask, and pulses `mem_resp` for exactly one cycle per completed transaction. It sits between the LC-3b core and an on-chip word array. It serves as the synthesizable memory for FPGA bring-up and as the bench memory for core verification.

## Interface
- `ADDR_BITS`, default 8: word-address width; the array holds 2^ADDR_BITS 16-bit words.
- `LATENCY`, default 3: cycles from request acceptance to `mem_resp`; legal range 1..15.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `mem_read` input 1: read request (lc3b initiator).
- `mem_write` input 1: write request.
- `mem_address` input 16: byte address (lc3b_word); bit 0 is ignored; bits [ADDR_BITS:1] select the word.
- `mem_wdata` input 16: write data (lc3b_word).
- `mem_byte_enable` input 2: lc3b_mem_wmask; bit 1 enables the high byte, bit 0 the low byte.
- `mem_resp` output 1: one-cycle completion pulse.
- `mem_rdata` output 16: read data, valid only while `mem_resp` is high for a read.
- `proto_err` output 1: sticky protocol-violation flag.

## Operation
- FSM states:
  - IDLE: no transaction in progress.
  - BUSY: 4-bit down-counter running.
  - RESP: completion cycle.
- IDLE:
  - If `mem_read` or `mem_write` is high at the edge, latch the operation, word index, `mem_wdata` and `mem_byte_enable`.
  - Load the counter with LATENCY-1.
  - Go to BUSY, or directly to RESP when LATENCY=1.
- BUSY:
  - Decrement the counter. At counter 1, go to RESP.
  - If both `mem_read` and `mem_write` are low at an edge, abort. Go to IDLE with no array write and no `mem_resp`.
- RESP:
  - `mem_resp`=1.
  - On a read, `mem_rdata` = array[latched index].
  - On a write, commit masked bytes at this cycle's closing edge. Unmasked bytes are unchanged. A mask of 2'b00 completes with no change.
  - Always return to IDLE.
- After RESP, the responder spends at least one cycle in IDLE. A request still asserted in that IDLE cycle is treated as a new transaction.
- Both `mem_read` and `mem_write` high at acceptance: write wins.
- Address wrap: bits above ADDR_BITS are ignored, so index = `mem_address[ADDR_BITS:1]`.
- `mem_rdata` is a register. It holds its last value outside RESP and is 0 after reset. The array contents are not reset.
- `proto_err` is cleared only by reset.

## Timing
- Request high at the edge that enters BUSY (edge k): `mem_resp` is high in cycle k+LATENCY, i.e. after edge k+LATENCY-1 and before edge k+LATENCY.
- Minimum spacing between `mem_resp` pulses: LATENCY+1 cycles.
- A write is visible to a read accepted at any later IDLE.
- Reset values: `mem_resp`=0, `mem_rdata`=16'h0000, `proto_err`=0, FSM=IDLE, counter=0.
- Reset asserted mid-BUSY or mid-RESP:
  - Outputs go to reset values immediately.
  - A pending write is not committed.
  - The first request after `rst_n` rises is accepted at the first edge.

## Configuration
- `LC3B_MEM_PROTOCOL_CHECK_EN` defined:
  - `proto_err` sets on read and write both high at acceptance.
  - It sets on any change of `mem_address`, `mem_wdata`, `mem_byte_enable` or operation while in BUSY or RESP.
  - It sets on an abort.
  - Behaviour of the transaction itself is unchanged.
- Macro undefined: `proto_err` is tied 0 and no checking logic is built. Write-wins and abort behaviour remain.

## Test plan
- Reset then read, LATENCY=3: `mem_read`=1 at `mem_address`=16'h0004 on an IDLE edge → `mem_resp` high for exactly one cycle, 3 cycles later, with `mem_rdata` = array[2]; `mem_resp` and `mem_rdata` are 0 during reset.
- Byte-masked write: write 16'hBEEF to 16'h0010 with mask 2'b11, then write 16'h12AB with mask 2'b01, then read → 16'hBEAB; a write with mask 2'b00 leaves 16'hBEAB.
- Back-to-back requests: hold `mem_read` continuously with LATENCY=2 → `mem_resp` pulses every 3 cycles; with LATENCY=1 → every 2 cycles.
- Abort: drop `mem_write` in the second BUSY cycle of a write of 16'h5555 to 16'h0020 → no `mem_resp`; a later read of 16'h0020 returns the old value; with the macro on, `proto_err`=1.
- Conflict and wrap, ADDR_BITS=8: read+write high together on 16'h0202 with data 16'hA5A5 → a write is performed; a read of 16'h0002 returns 16'hA5A5; `proto_err`=1 with the macro on and 0 with it off.
- Async reset mid-write: assert `rst_n`=0 during BUSY → `mem_resp` stays 0, the target word is unchanged, and a new read completes normally after release.

Source files
------------

// File: rtl/lc3b_mem_responder.sv
// LC-3b single-port memory responder: fixed-latency read/write with byte mask and abort.
// Optional protocol checker enabled by defining LC3B_MEM_PROTOCOL_CHECK_EN.
module lc3b_mem_responder #(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  input  logic [1:0]  mem_byte_enable,
  output logic        mem_resp,
  output logic [15:0] mem_rdata,
  output logic        proto_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LOAD_VAL = 4'(LATENCY - 1);

  state_t                 state, state_nxt;
  logic [3:0]             cnt, cnt_nxt;
  logic                   load;
  logic                   req;
  logic                   op_wr;
  logic [ADDR_BITS-1:0]   idx;
  logic [15:0]            wdata_q;
  logic [1:0]             be_q;
  logic                   rd_sel;
  logic [ADDR_BITS-1:0]   rd_idx;
  logic [15:0]            mem [2**ADDR_BITS];
  logic                   unused_addr_bits;

  assign req      = mem_read | mem_write;
  assign mem_resp = (state == RESP);
  // Byte-select bit and high address bits never reach the array.
  assign unused_addr_bits = ^{mem_address[15:ADDR_BITS+1], mem_address[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          load      = 1'b1;
          cnt_nxt   = LOAD_VAL;
          state_nxt = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        // Dropping the request aborts, even on the cycle that would complete.
        if (!req) begin
          cnt_nxt   = 4'd0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
          if (cnt == 4'd1) state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = 4'd0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_wr   <= 1'b0;
      idx     <= '0;
      wdata_q <= 16'h0000;
      be_q    <= 2'b00;
    end else if (load) begin
      op_wr   <= mem_write;
      idx     <= mem_address[ADDR_BITS:1];
      wdata_q <= mem_wdata;
      be_q    <= mem_byte_enable;
    end
  end

  // With LATENCY=1 the read index comes straight from the bus on the accept edge.
  assign rd_sel = (state == IDLE) ? (mem_read & ~mem_write) : ~op_wr;
  assign rd_idx = (state == IDLE) ? mem_address[ADDR_BITS:1] : idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rdata <= 16'h0000;
    end else if (state_nxt == RESP && state != RESP && rd_sel) begin
      mem_rdata <= mem[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (state == RESP && op_wr) begin
      if (be_q[1]) mem[idx][15:8] <= wdata_q[15:8];
      if (be_q[0]) mem[idx][7:0]  <= wdata_q[7:0];
    end
  end

`ifdef LC3B_MEM_PROTOCOL_CHECK_EN
  logic [15:0] addr_q;
  logic [1:0]  op_q;
  logic        err_q;
  logic        changed;

  assign changed = (mem_address != addr_q) || (mem_wdata != wdata_q) ||
                   (mem_byte_enable != be_q) || ({mem_read, mem_write} != op_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= 16'h0000;
      op_q   <= 2'b00;
      err_q  <= 1'b0;
    end else begin
      if (load) begin
        addr_q <= mem_address;
        op_q   <= {mem_read, mem_write};
      end
      // An abort shows up here as an operation change.
      if ((load && mem_read && mem_write) || (state != IDLE && changed)) err_q <= 1'b1;
    end
  end

  assign proto_err = err_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Self-checking bench for lc3b_mem_responder: directed scenarios plus random traffic
// against a word-array model; extra instances cover LATENCY=2 and LATENCY=1 pacing.
module tb_lc3b_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd, wr;
  logic [15:0] addr, wdata;
  logic [1:0]  be;
  logic        resp3, resp2, resp1;
  logic [15:0] rdata3, rdata2, rdata1;
  logic        perr3, perr2, perr1;

  int errors = 0;
  int checks = 0;

  logic [15:0] model [256];
  logic [15:0] last_rd;

`ifdef LC3B_MEM_PROTOCOL_CHECK_EN
  localparam logic PERR_ON = 1'b1;
`else
  localparam logic PERR_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  lc3b_mem_responder #(.ADDR_BITS(8), .LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mem_read(rd), .mem_write(wr), .mem_address(addr),
    .mem_wdata(wdata), .mem_byte_enable(be), .mem_resp(resp3), .mem_rdata(rdata3),
    .proto_err(perr3));

  lc3b_mem_responder #(.ADDR_BITS(8), .LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .mem_read(rd), .mem_write(wr), .mem_address(addr),
    .mem_wdata(wdata), .mem_byte_enable(be), .mem_resp(resp2), .mem_rdata(rdata2),
    .proto_err(perr2));

  lc3b_mem_responder #(.ADDR_BITS(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .mem_read(rd), .mem_write(wr), .mem_address(addr),
    .mem_wdata(wdata), .mem_byte_enable(be), .mem_resp(resp1), .mem_rdata(rdata1),
    .proto_err(perr1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full transaction on the LATENCY=3 instance, checked against the model.
  task automatic txn(input bit r, input bit w, input logic [15:0] a, input logic [15:0] d,
                     input logic [1:0] b, input string tag);
    int          lat;
    bit          got;
    logic [7:0]  i;
    logic [15:0] m;
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d; be = b;
    lat = 0;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      cycle();
      lat++;
      if (resp3) got = 1;
    end
    check({tag, " resp_seen"}, 32'(got), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'd3);
    i = a[8:1];
    if (w) begin
      m = {{8{b[1]}}, {8{b[0]}}};
      model[i] = (model[i] & ~m) | (d & m);
    end else begin
      last_rd = model[i];
    end
    check({tag, " rdata"}, 32'(rdata3), 32'(last_rd));
    cycle();
    check({tag, " resp_one_cycle"}, 32'(resp3), 32'd0);
    check({tag, " rdata_hold"}, 32'(rdata3), 32'(last_rd));
    rd = 1'b0; wr = 1'b0;
  endtask

  initial begin
    int          n;
    int          p1[$], p2[$], p3[$];
    logic [15:0] old, ra;
    logic [7:0]  ri;
    bit          rr, rw;

    rst_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = 16'h0; wdata = 16'h0; be = 2'b00;
    last_rd = 16'h0000;
    repeat (3) cycle();
    check("reset resp", 32'(resp3), 32'd0);
    check("reset rdata", 32'(rdata3), 32'd0);
    check("reset proto_err", 32'(perr3), 32'd0);
    rst_n = 1'b1;

    for (int k = 0; k < 32; k++)
      txn(1'b0, 1'b1, 16'(k * 2), 16'($urandom), 2'b11, "init");

    txn(1'b1, 1'b0, 16'h0004, 16'h0000, 2'b00, "read_0004");

    txn(1'b0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, "wr_beef");
    txn(1'b0, 1'b1, 16'h0010, 16'h12AB, 2'b01, "wr_lo");
    txn(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, "rd_mask");
    check("masked value", 32'(rdata3), 32'h0000BEAB);
    txn(1'b0, 1'b1, 16'h0010, 16'hFFFF, 2'b00, "wr_none");
    txn(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, "rd_none");
    check("mask00 value", 32'(rdata3), 32'h0000BEAB);

    txn(1'b1, 1'b1, 16'h0202, 16'hA5A5, 2'b11, "conflict");
    txn(1'b1, 1'b0, 16'h0002, 16'h0000, 2'b00, "rd_wrap");
    check("wrap value", 32'(rdata3), 32'h0000A5A5);
    check("conflict proto_err", 32'(perr3), 32'(PERR_ON));

    // Abort: write dropped in its second BUSY cycle.
    old = model[8'h10];
    @(negedge clk);
    wr = 1'b1; addr = 16'h0020; wdata = 16'h5555; be = 2'b11;
    cycle();
    cycle();
    wr = 1'b0;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (resp3) n++;
    end
    check("abort no resp", 32'(n), 32'd0);
    txn(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, "rd_abort");
    check("abort old value", 32'(rdata3), 32'(old));
    check("abort proto_err", 32'(perr3), 32'(PERR_ON));

    // Async reset during BUSY of a write.
    old = model[8'h18];
    @(negedge clk);
    wr = 1'b1; addr = 16'h0030; wdata = ~old; be = 2'b11;
    cycle();
    #2 rst_n = 1'b0;
    #1;
    check("rst resp", 32'(resp3), 32'd0);
    check("rst rdata", 32'(rdata3), 32'd0);
    check("rst proto_err", 32'(perr3), 32'd0);
    wr = 1'b0;
    last_rd = 16'h0000;
    repeat (2) cycle();
    check("rst hold resp", 32'(resp3), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    txn(1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00, "rd_after_rst");
    check("rst no commit", 32'(rdata3), 32'(old));

    for (int k = 0; k < 40; k++) begin
      ri = 8'($urandom_range(0, 31));
      ra = 16'($urandom);
      ra[8:1] = ri;
      rr = 1'($urandom);
      rw = 1'($urandom);
      if (!rr && !rw) rr = 1'b1;
      txn(rr, rw, ra, 16'($urandom), 2'($urandom), "random");
    end

    // Held read: pacing of LATENCY=3/2/1 instances.
    repeat (4) cycle();
    rd = 1'b1; addr = 16'h0010;
    last_rd = model[8'h08];
    for (int c = 1; c <= 16; c++) begin
      cycle();
      if (resp1) p1.push_back(c);
      if (resp2) p2.push_back(c);
      if (resp3) begin
        p3.push_back(c);
        check("b2b rdata", 32'(rdata3), 32'(last_rd));
      end
    end
    rd = 1'b0;
    check("b2b L1 count", 32'(p1.size()), 32'd8);
    check("b2b L2 count", 32'(p2.size()), 32'd5);
    check("b2b L3 count", 32'(p3.size()), 32'd4);
    if (p1.size() > 0) check("b2b L1 first", 32'(p1[0]), 32'd1);
    if (p2.size() > 0) check("b2b L2 first", 32'(p2[0]), 32'd2);
    if (p3.size() > 0) check("b2b L3 first", 32'(p3[0]), 32'd3);
    for (int k = 1; k < p1.size(); k++) check("b2b L1 gap", 32'(p1[k] - p1[k-1]), 32'd2);
    for (int k = 1; k < p2.size(); k++) check("b2b L2 gap", 32'(p2[k] - p2[k-1]), 32'd3);
    for (int k = 1; k < p3.size(); k++) check("b2b L3 gap", 32'(p3[k] - p3[k-1]), 32'd4);

    repeat (4) cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
